// File: rtl/interval_timer.sv
// interval_timer: programmable interval timer serving the traffic-light FSM.
// Holds the base, extended and yellow interval lengths. On a start pulse it
// counts down the selected interval, one second per CLK_DIV clock cycles, and
// then emits a one-cycle expired pulse.
module interval_timer #(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] DEF_BASE = 4'd6,
    parameter logic [3:0] DEF_EXT  = 4'd3,
    parameter logic [3:0] DEF_YEL  = 4'd2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       Prog_Sync,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] time_left
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [3:0]       base_r;
    logic [3:0]       ext_r;
    logic [3:0]       yel_r;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       load_value;

    // Interval registers: a zero write restores the default, select 11 is ignored.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            base_r <= DEF_BASE;
            ext_r  <= DEF_EXT;
            yel_r  <= DEF_YEL;
        end else if (Prog_Sync) begin
            case (Time_Param_Sel)
                2'b00:   base_r <= (Time_Value == 4'd0) ? DEF_BASE : Time_Value;
                2'b01:   ext_r  <= (Time_Value == 4'd0) ? DEF_EXT  : Time_Value;
                2'b10:   yel_r  <= (Time_Value == 4'd0) ? DEF_YEL  : Time_Value;
                default: ;
            endcase
        end
    end

    // Pick the length to load on start; code 11 falls back to the base interval.
    always_comb begin
        load_value = base_r;
        case (interval)
            2'b01:   load_value = ext_r;
            2'b10:   load_value = yel_r;
            default: load_value = base_r;
        endcase
    end

    assign busy = (state == RUN);
    assign tick = busy && (div_cnt == DIV_LAST);

    // Countdown FSM: a start always wins, even over the final tick of a run.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            time_left <= 4'd0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (start_timer) begin
                time_left <= load_value;
                div_cnt   <= '0;
                state     <= RUN;
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt   <= '0;
                        time_left <= 4'd0;
                    end
                    RUN: begin
                        if (tick) begin
                            div_cnt <= '0;
                            if (time_left > 4'd1) begin
                                time_left <= time_left - 4'd1;
                            end else begin
                                time_left <= 4'd0;
                                expired   <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Testbench for interval_timer: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a model that
// predicts the outputs from start times and loaded lengths.
module tb_interval_timer;

    localparam int CLK_DIV  = 4;
    localparam int DEF_BASE = 6;
    localparam int DEF_EXT  = 3;
    localparam int DEF_YEL  = 2;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval = 2'b00;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Time_Param_Sel = 2'b00;
    logic [3:0] Time_Value = 4'd0;
    logic       expired;
    logic       busy;
    logic [3:0] time_left;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;
    int lat;

    always #5 clk = ~clk;

    interval_timer #(
        .CLK_DIV (CLK_DIV),
        .DEF_BASE(4'(DEF_BASE)),
        .DEF_EXT (4'(DEF_EXT)),
        .DEF_YEL (4'(DEF_YEL))
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .Prog_Sync     (Prog_Sync),
        .Time_Param_Sel(Time_Param_Sel),
        .Time_Value    (Time_Value),
        .expired       (expired),
        .busy          (busy),
        .time_left     (time_left)
    );

    // Reference model: a run is described by its start edge and loaded length;
    // it ends exactly N*CLK_DIV edges later unless restarted.
    int m_regs[3];
    bit m_run;
    bit m_exp;
    bit m_ended;
    int m_cyc;
    int m_start;
    int m_n;
    int m_pick;

    function automatic int defOf(input int idx);
        case (idx)
            1:       return DEF_EXT;
            2:       return DEF_YEL;
            default: return DEF_BASE;
        endcase
    endfunction

    function automatic int expTimeLeft();
        if (!m_run) return 0;
        return m_n - (m_cyc - m_start) / CLK_DIV;
    endfunction

    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            m_regs[0] = DEF_BASE;
            m_regs[1] = DEF_EXT;
            m_regs[2] = DEF_YEL;
            m_run     = 1'b0;
            m_exp     = 1'b0;
            m_cyc     = 0;
            m_start   = 0;
            m_n       = 0;
        end else begin
            m_cyc++;
            m_ended = m_run && (m_cyc == m_start + m_n * CLK_DIV);
            if (start_timer) begin
                m_pick  = (interval == 2'b01) ? 1 : (interval == 2'b10) ? 2 : 0;
                m_run   = 1'b1;
                m_start = m_cyc;
                m_n     = m_regs[m_pick];
                m_exp   = 1'b0;
            end else if (m_ended) begin
                m_run = 1'b0;
                m_exp = 1'b1;
            end else begin
                m_exp = 1'b0;
            end
            if (Prog_Sync && Time_Param_Sel != 2'b11)
                m_regs[Time_Param_Sel] = (Time_Value == 4'd0) ? defOf(int'(Time_Param_Sel)) : int'(Time_Value);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of DUT outputs with the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("busy", int'(busy), int'(m_run));
            checkOutput("time_left", int'(time_left), expTimeLeft());
            checkOutput("expired", int'(expired), int'(m_exp));
        end
    end

    task automatic applyStimulus(input bit st, input logic [1:0] intv, input bit prog,
                                 input logic [1:0] sel, input logic [3:0] val);
        @(negedge clk);
        start_timer    = st;
        interval       = intv;
        Prog_Sync      = prog;
        Time_Param_Sel = sel;
        Time_Value     = val;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic startPulse(input logic [1:0] intv);
        applyStimulus(1'b1, intv, 1'b0, 2'b00, 4'd0);
        idleInputs();
    endtask

    task automatic progWrite(input logic [1:0] sel, input logic [3:0] val);
        applyStimulus(1'b0, 2'b00, 1'b1, sel, val);
        idleInputs();
    endtask

    // Counts edges after the start edge until expired is seen, bounded.
    task automatic waitExpired(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (expired) break;
        end
        if (!expired) begin
            checkOutput("expire_timeout", 0, 1);
            cycles = -1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_time_left", int'(time_left), 0);
        checkOutput("reset_expired", int'(expired), 0);
        model_on = 1'b1;
        #3 Reset = 1'b1;

        // Default base interval
        startPulse(2'b00);
        checkOutput("default_first_tl", int'(time_left), 6);
        waitExpired(lat);
        checkOutput("default_latency", lat, 24);
        checkOutput("default_busy_at_expire", int'(busy), 0);

        // Program extended, then restore its default
        progWrite(2'b01, 4'd5);
        startPulse(2'b01);
        waitExpired(lat);
        checkOutput("ext5_latency", lat, 20);
        progWrite(2'b01, 4'd0);
        startPulse(2'b01);
        waitExpired(lat);
        checkOutput("ext_default_latency", lat, 12);

        // Restart yellow with base mid-run
        startPulse(2'b10);
        repeat (4) @(negedge clk);
        startPulse(2'b00);
        waitExpired(lat);
        checkOutput("restart_latency", lat, 24);

        // Start on the final tick of a yellow interval
        startPulse(2'b10);
        repeat (6) @(negedge clk);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
        idleInputs();
        checkOutput("collide_expired", int'(expired), 0);
        checkOutput("collide_busy", int'(busy), 1);
        checkOutput("collide_tl", int'(time_left), 6);
        waitExpired(lat);
        checkOutput("collide_latency", lat, 24);

        // Asynchronous reset mid-count restores defaults
        progWrite(2'b00, 4'd9);
        startPulse(2'b00);
        repeat (10) @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_tl", int'(time_left), 0);
        checkOutput("async_expired", int'(expired), 0);
        @(negedge clk);
        #3 Reset = 1'b1;
        startPulse(2'b00);
        waitExpired(lat);
        checkOutput("post_reset_latency", lat, 24);

        // Reserved codes
        startPulse(2'b11);
        waitExpired(lat);
        checkOutput("interval11_latency", lat, 24);
        progWrite(2'b11, 4'd7);
        startPulse(2'b00);
        waitExpired(lat);
        checkOutput("sel11_base", lat, 24);
        startPulse(2'b01);
        waitExpired(lat);
        checkOutput("sel11_ext", lat, 12);
        startPulse(2'b10);
        waitExpired(lat);
        checkOutput("sel11_yel", lat, 8);

        // Program and start the same register on the same edge
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b00, 4'd9);
        idleInputs();
        waitExpired(lat);
        checkOutput("same_edge_old_value", lat, 24);
        startPulse(2'b00);
        waitExpired(lat);
        checkOutput("same_edge_new_value", lat, 36);

        // Randomized traffic, including occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 29) == 0,
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 1'b0;
                #4 Reset = 1'b1;
            end
        end
        idleInputs();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        checkOutput("drain_idle", int'(busy), 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer that sits beside the traffic-light FSM and serves as its timing resource. It stores the base, extended and yellow interval lengths and reloads them when the operator programs new values. On each `start_timer` pulse it counts down the interval selected by the FSM using an internal seconds prescaler. When the interval ends it returns a one-cycle `expired` pulse.

## Interface
Parameters:
- `CLK_DIV`, 4: clock cycles per one-second tick; legal range ≥ 2.
- `DEF_BASE`, 6: reset/default base interval, in seconds.
- `DEF_EXT`, 3: reset/default extended interval, in seconds.
- `DEF_YEL`, 2: reset/default yellow interval, in seconds.

Ports:
- `clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start_timer`  in  1  one-cycle request to load and start the interval.
- `interval`  in  2  interval select: 00 base, 01 extended, 10 yellow, 11 treated as base.
- `Prog_Sync`  in  1  synchronized program strobe; writes `Time_Value` into the selected register.
- `Time_Param_Sel`  in  2  register to write: 00 base, 01 extended, 10 yellow, 11 no write.
- `Time_Value`  in  4  new interval in seconds; 0 means "restore default".
- `expired`  out  1  one-cycle pulse at the end of the interval.
- `busy`  out  1  high while counting.
- `time_left`  out  4  remaining seconds; 0 when idle.

## Operation
- Three registers, each 4 bits: `base_r`, `ext_r`, `yel_r`. They reset to `DEF_*`.
- Programming:
  - On a clock edge with `Prog_Sync`=1, the register chosen by `Time_Param_Sel` gets `Time_Value`.
  - If `Time_Value`=0, that register gets its `DEF_*` value instead.
  - `Time_Param_Sel`=11 performs no write.
- Prescaler `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `tick` = `busy` && `div_cnt`==`CLK_DIV`-1 (combinational).
- State machine with two states, IDLE and RUN:
  - Any state, `start_timer`=1: `time_left` ← selected register, `div_cnt` ← 0, go to RUN. A restart during RUN discards the remaining count.
  - RUN, `tick` with `time_left`>1: `time_left` decrements by 1.
  - RUN, `tick` with `time_left`==1: `time_left` ← 0, `expired` ← 1, go to IDLE.
  - IDLE: `div_cnt` is held at 0.
- `expired` is registered and clears on the next edge.
- `busy` = (state==RUN).
- Priority on the same edge: `start_timer` beats the final tick. A start coinciding with the last tick reloads the timer and produces no `expired` pulse.
- Programming is independent of counting:
  - A `Prog_Sync` write during RUN changes only future loads.
  - If `Prog_Sync` and `start_timer` hit the same edge for the same register, the load uses the old value.
- Reset, asserted at any time including mid-count:
  - Registers return to their defaults.
  - State goes to IDLE.
  - `div_cnt`, `time_left` and `expired` go to 0.

## Timing
- Reset values: `expired`=0, `busy`=0, `time_left`=0, `div_cnt`=0, registers at `DEF_*`.
- Start edge E0 (`start_timer` sampled high):
  - `busy`=1 and `time_left`=N right after E0.
  - Each decrement lands at edge E0+k·`CLK_DIV`, for k=1..N.
- `expired` is high for exactly the one cycle following edge E0+N·`CLK_DIV`. Latency from start to `expired` is N·`CLK_DIV` cycles.
- `busy` falls at the same edge that `expired` rises.
- A program write is visible to a `start_timer` sampled one edge or more later.
- The FSM may pulse `start_timer` in the cycle `expired` is high. That pulse is accepted normally, with no dead cycle.

## Test plan
- Defaults: release reset, `CLK_DIV`=4, pulse `start_timer` with `interval`=00 → `time_left` counts 6..1, `expired` high for exactly one cycle 24 cycles after the start edge, `busy` then 0.
- Programming: `Prog_Sync`=1, `Time_Param_Sel`=01, `Time_Value`=5, then start with `interval`=01 → `expired` after 20 cycles. Write 0 to the same register, start again → `expired` after 12 cycles (default 3).
- Restart: start yellow (2 s), then after 5 cycles start base → no `expired` at cycle 8; `expired` 24 cycles after the second start.
- Collision: assert `start_timer` on the final-tick edge of a yellow interval → no `expired` pulse, `time_left` reloads to the new interval, `busy` stays 1.
- Reset mid-run: program `base_r`=9, start base, pull `Reset` low asynchronously mid-count → `busy`/`time_left`/`expired` drop immediately. After release, start base → `expired` after 24 cycles (default 6 restored).
- Reserved codes: `interval`=11 loads base. `Time_Param_Sel`=11 with `Prog_Sync` leaves all registers unchanged.
